fetch_unit: RTL and testbench

Instruction fetch stage for the pipelined core. Owns the PC, drives the instruction-cache read request, and produces the registered IF/ID word (`instr`, PC, PC+4, valid) that decode and the control unit consume. Accepts taken-branch/jump redirects and a halt indication back from decode, and honours hazard-unit stalls. Tolerates cache misses by holding the request address stable until `ihit`.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues instruction-cache
// reads, and registers the IF/ID word (instr, pc, pc+4, valid) for decode.
// Handles branch/jump redirects, HALT, hazard stalls and cache misses.
// Optional build macro FETCH_PERF_EN adds fetch/bubble performance counters.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_npc,
  output logic        valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  // FETCH: normal issue. DRAIN: waiting out a miss whose word will be thrown
  // away. HALT: terminal until reset.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        halt_pend;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Targets are word aligned; the low bits from decode are ignored.
  assign target   = {redirect_pc[31:2], 2'b00};
  assign pc_plus4 = pc + 32'd4;

  // Cache request depends only on registered state, so the address cannot
  // glitch with late decode/hazard inputs and stays put across a miss.
  assign imemREN  = (state != ST_HALT);
  assign imemaddr = pc;
  assign halted   = (state == ST_HALT);

  // PC, pending-target and IF/ID register update, one FSM step per edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_FETCH;
      pc        <= PC_INIT;
      pend_pc   <= 32'h0;
      halt_pend <= 1'b0;
      instr     <= 32'h0;
      instr_pc  <= 32'h0;
      instr_npc <= 32'h0;
      valid     <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all branches see the values from
      // before the edge (pc_plus4 and pend_pc read the old pc, not the new one).
      case (state)
        ST_FETCH: begin
          if (redirect) begin
            valid <= 1'b0;
            instr <= 32'h0;
            if (ihit) begin
              pc <= target;
            end else begin
              pend_pc <= target;
              state   <= ST_DRAIN;
            end
          end else if (halt && !stall) begin
            valid <= 1'b0;
            instr <= 32'h0;
            if (ihit) begin
              state <= ST_HALT;
            end else begin
              halt_pend <= 1'b1;
              pend_pc   <= pc;
              state     <= ST_DRAIN;
            end
          end else if (stall) begin
            // IF/ID and pc hold; a word returned now is refetched later.
          end else if (ihit) begin
            instr     <= imemload;
            instr_pc  <= pc;
            instr_npc <= pc_plus4;
            valid     <= 1'b1;
            pc        <= pc_plus4;
          end else begin
            valid <= 1'b0;
            instr <= 32'h0;
          end
        end

        ST_DRAIN: begin
          valid <= 1'b0;
          instr <= 32'h0;
          if (redirect) pend_pc   <= target;
          if (halt)     halt_pend <= 1'b1;
          if (ihit) begin
            // The returned word belongs to the abandoned path and is dropped.
            if (halt_pend || halt) begin
              state <= ST_HALT;
            end else begin
              pc    <= redirect ? target : pend_pc;
              state <= ST_FETCH;
            end
          end
        end

        ST_HALT: begin
          valid <= 1'b0;
          instr <= 32'h0;
        end

        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic load_valid;
  logic load_bubble;

  // Classify this edge's IF/ID update: real load, counted bubble, or neither
  // (stall hold, halt flush, halted).
  always_comb begin
    // NOTE: defaults first so every path assigns both flags and no latch forms.
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    case (state)
      ST_FETCH: begin
        if (redirect)              load_bubble = 1'b1;
        else if (halt && !stall)   load_bubble = 1'b0;
        else if (stall)            load_bubble = 1'b0;
        else if (ihit)             load_valid  = 1'b1;
        else                       load_bubble = 1'b1;
      end
      ST_DRAIN: load_bubble = 1'b1;
      default:  load_bubble = 1'b0;
    endcase
  end

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count  <= 32'h0;
      bubble_count <= 32'h0;
    end else begin
      if (load_valid)  fetch_count  <= fetch_count + 32'd1;
      if (load_bubble) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with an instruction memory
// whose word equals its address. A behavioural model of the fetch stage is
// compared against the DUT every cycle, and literal expectations pin key points.
module tb_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_npc;
  logic        valid;
  logic        halted;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_npc   (instr_npc),
    .valid       (valid),
    .halted      (halted)
  );

  // Memory: the word stored at an address is the address itself.
  assign imemload = imemaddr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;          // address being requested
    logic        waiting;     // outstanding miss to throw away
    logic [31:0] tgt;         // where to go once it returns
    logic        stop_after;  // stop instead of resuming
    logic        stopped;     // fetch finished for good
    logic        ifid_valid;
    logic [31:0] ifid_pc;
  } mdl_t;

  localparam mdl_t MDL_RESET = '{pc: 32'h0, waiting: 1'b0, tgt: 32'h0,
                                 stop_after: 1'b0, stopped: 1'b0,
                                 ifid_valid: 1'b0, ifid_pc: 32'h0};

  function automatic mdl_t model_step(input mdl_t s, input logic hit, input logic stl,
                                      input logic rdr, input logic [31:0] rpc,
                                      input logic hlt);
    mdl_t        n;
    logic [31:0] t;
    n = s;
    t = rpc & 32'hFFFF_FFFC;
    if (s.stopped) begin
      n.ifid_valid = 1'b0;
    end else if (s.waiting) begin
      n.ifid_valid = 1'b0;
      if (rdr) n.tgt = t;
      if (hlt) n.stop_after = 1'b1;
      if (hit) begin
        n.waiting = 1'b0;
        if (n.stop_after) n.stopped = 1'b1;
        else              n.pc = n.tgt;
      end
    end else if (rdr) begin
      n.ifid_valid = 1'b0;
      if (hit) n.pc = t;
      else begin n.waiting = 1'b1; n.tgt = t; end
    end else if (hlt && !stl) begin
      n.ifid_valid = 1'b0;
      if (hit) n.stopped = 1'b1;
      else begin n.waiting = 1'b1; n.stop_after = 1'b1; n.tgt = s.pc; end
    end else if (stl) begin
      n = s;
    end else if (hit) begin
      n.ifid_valid = 1'b1;
      n.ifid_pc    = s.pc;
      n.pc         = s.pc + 32'd4;
    end else begin
      n.ifid_valid = 1'b0;
    end
    return n;
  endfunction

  mdl_t m;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) m <= MDL_RESET;
    else       m <= model_step(m, ihit, stall, redirect, redirect_pc, halt);
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      check("imemREN", {31'b0, imemREN}, {31'b0, !m.stopped});
      check("imemaddr", imemaddr, m.pc);
      check("halted", {31'b0, halted}, {31'b0, m.stopped});
      check("valid", {31'b0, valid}, {31'b0, m.ifid_valid});
      if (m.ifid_valid) begin
        check("instr", instr, m.ifid_pc);
        check("instr_pc", instr_pc, m.ifid_pc);
        check("instr_npc", instr_npc, m.ifid_pc + 32'd4);
      end else begin
        check("bubble_instr", instr, 32'h0);
      end
    end
  end

  // Advance n rising edges; inputs change 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    check("rst_imemaddr", imemaddr, 32'h0);
    check("rst_imemREN", {31'b0, imemREN}, 32'd1);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    step(1);
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; ihit = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0;
    step(1);
    #1;
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_instr_npc", instr_npc, 32'h0);
    check("rst_valid0", {31'b0, valid}, 32'd0);
    check("rst_addr0", imemaddr, 32'h0);
    step(1);
    nRST = 1'b1;

    // Back-to-back hits from 0: third edge shows PC 8.
    step(3);
    check("tp_valid", {31'b0, valid}, 32'd1);
    check("tp_instr", instr, 32'h8);
    check("tp_instr_pc", instr_pc, 32'h8);
    check("tp_instr_npc", instr_npc, 32'hC);

    // Miss at 0x10 for 4 cycles.
    step(1);
    ihit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("miss_valid", {31'b0, valid}, 32'd0);
      check("miss_addr", imemaddr, 32'h10);
    end
    ihit = 1'b1;
    step(1);
    check("miss_resume_pc", instr_pc, 32'h10);

    // Stall at 0x20 with ihit high.
    step(3);
    stall = 1'b1;
    step(2);
    check("stall_hold_pc", instr_pc, 32'h1C);
    check("stall_hold_valid", {31'b0, valid}, 32'd1);
    check("stall_addr", imemaddr, 32'h20);
    stall = 1'b0;
    step(1);
    check("stall_resume_pc", instr_pc, 32'h20);

    // Redirect during a miss at 0x30 (low target bits set and ignored).
    step(3);
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0403;
    step(1);
    redirect = 1'b0;
    step(2);
    check("rdm_addr_held", imemaddr, 32'h30);
    ihit = 1'b1;
    step(1);
    check("rdm_discard", {31'b0, valid}, 32'd0);
    check("rdm_target", imemaddr, 32'h400);
    step(1);
    check("rdm_first", instr_pc, 32'h400);

    // Redirect with a hit: target requested next cycle.
    redirect = 1'b1; redirect_pc = 32'h100;
    step(1);
    redirect = 1'b0;
    check("rdh_addr", imemaddr, 32'h100);
    check("rdh_flush", {31'b0, valid}, 32'd0);
    step(1);

    // Halt under stall is held off by the stall.
    halt = 1'b1; stall = 1'b1;
    step(1);
    check("halt_stall_not_halted", {31'b0, halted}, 32'd0);
    check("halt_stall_hold", instr_pc, 32'h100);

    // Halt during a miss: waits for the outstanding hit.
    stall = 1'b0; ihit = 1'b0;
    step(1);
    halt = 1'b0;
    step(1);
    check("halt_miss_wait", {31'b0, halted}, 32'd0);
    check("halt_miss_addr", imemaddr, 32'h104);
    ihit = 1'b1;
    step(1);
    check("halt_miss_done", {31'b0, halted}, 32'd1);

    // Reset restarts fetch from the reset PC.
    do_reset();
    step(2);
    check("restart_pc", instr_pc, 32'h4);

    // Halt with a hit: halted next cycle, held.
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("halt_halted", {31'b0, halted}, 32'd1);
      check("halt_ren", {31'b0, imemREN}, 32'd0);
      check("halt_valid", {31'b0, valid}, 32'd0);
      step(1);
    end
    do_reset();

    // Wrap: fetch from 0xFFFF_FFFC then 0.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step(1);
    redirect = 1'b0;
    check("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    step(1);
    check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_npc", instr_npc, 32'h0);
    check("wrap_next_addr", imemaddr, 32'h0);
    step(1);
    check("wrap_after", instr_pc, 32'h0);

    // A second redirect while draining replaces the first target.
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    step(1);
    redirect_pc = 32'h300;
    step(1);
    redirect = 1'b0; ihit = 1'b1;
    step(1);
    check("rd_overwrite_addr", imemaddr, 32'h300);
    step(1);
    check("rd_overwrite_pc", instr_pc, 32'h300);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
